// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU UART command path: FSM encoding, ASCII constants,
// opcodes shared with the RX parser, and emit-sequencing helpers.
package alu_uart_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StLatch    = 4'd1,
    StSub100   = 4'd2,
    StSub10    = 4'd3,
    StEmitSign = 4'd4,
    StEmitH    = 4'd5,
    StEmitT    = 4'd6,
    StEmitU    = 4'd7,
    StEmitCr   = 4'd8,
    StEmitLf   = 4'd9,
    StFin      = 4'd10
  } state_e;

  localparam logic [7:0] CHR_ZERO  = 8'h30;
  localparam logic [7:0] CHR_MINUS = 8'h2D;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_AND = 8'h26;
  localparam logic [7:0] OP_OR  = 8'h7C;

  function automatic logic is_emit(state_e s);
    return (s >= StEmitSign) && (s <= StEmitLf);
  endfunction

  // Next state after `cur`, skipping emit states whose character is suppressed.
  function automatic state_e next_emit(state_e cur, logic neg, logic hund_nz, logic tens_nz,
                                       logic eol_en);
    if (cur < StEmitSign && neg) return StEmitSign;
    if (cur < StEmitH && hund_nz) return StEmitH;
    if (cur < StEmitT && (hund_nz || tens_nz)) return StEmitT;
    if (cur < StEmitU) return StEmitU;
    if (cur < StEmitCr && eol_en) return StEmitCr;
    if (cur < StEmitLf && eol_en) return StEmitLf;
    return StFin;
  endfunction

  function automatic logic [7:0] emit_char(state_e s, logic [3:0] hund, logic [3:0] tens,
                                           logic [3:0] units);
    case (s)
      StEmitSign: return CHR_MINUS;
      StEmitH:    return CHR_ZERO + {4'd0, hund};
      StEmitT:    return CHR_ZERO + {4'd0, tens};
      StEmitU:    return CHR_ZERO + {4'd0, units};
      StEmitCr:   return CHR_CR;
      StEmitLf:   return CHR_LF;
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_tx_seq_if.sv
// Parser/FIFO-side bundle of the ALU result transmitter.
interface alu_result_tx_seq_if #(
  parameter int unsigned NBIT = 8
);
  logic            START;
  logic [NBIT-1:0] RESULT;
  logic            FIFO_full;
  logic            WR_FIFO;
  logic [7:0]      data_out;
  logic            BUSY;
  logic            DONE;

  modport master (
    output START, RESULT, FIFO_full,
    input  WR_FIFO, data_out, BUSY, DONE
  );

  modport slave (
    input  START, RESULT, FIFO_full,
    output WR_FIFO, data_out, BUSY, DONE
  );
endinterface

// File: rtl/bin_to_dec_seq.sv
// Sequential two's-complement to sign + three BCD digits converter using
// repeated subtraction of 100 then 10.
module bin_to_dec_seq
  import alu_uart_pkg::*;
#(
  parameter int unsigned NBIT = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [NBIT-1:0] value,
  output logic            neg,
  output logic [3:0]      hund,
  output logic [3:0]      tens,
  output logic [3:0]      units,
  output logic            valid
);

  localparam logic [NBIT:0] MagOne     = (NBIT+1)'(1);
  localparam logic [NBIT:0] MagTen     = (NBIT+1)'(10);
  localparam logic [NBIT:0] MagHundred = (NBIT+1)'(100);

  state_e        state_q;
  logic [NBIT:0] mag_q;
  logic [NBIT:0] mag_in;
  logic          neg_q;
  logic [3:0]    hund_q;
  logic [3:0]    tens_q;
  logic          valid_q;

  // Extra magnitude bit so the most negative input (0x80) maps to 128.
  always_comb begin
    mag_in = {1'b0, value};
    if (value[NBIT-1]) mag_in = {1'b0, ~value} + MagOne;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: if (start) state_q <= StLatch;
        StLatch: begin
          neg_q   <= value[NBIT-1];
          mag_q   <= mag_in;
          hund_q  <= 4'd0;
          tens_q  <= 4'd0;
          state_q <= StSub100;
        end
        StSub100: begin
          if (mag_q >= MagHundred) begin
            mag_q  <= mag_q - MagHundred;
            hund_q <= hund_q + 4'd1;
          end else begin
            state_q <= StSub10;
          end
        end
        StSub10: begin
          if (mag_q >= MagTen) begin
            mag_q  <= mag_q - MagTen;
            tens_q <= tens_q + 4'd1;
          end else begin
            valid_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign neg   = neg_q;
  assign hund  = hund_q;
  assign tens  = tens_q;
  assign units = mag_q[3:0];
  assign valid = valid_q;

endmodule

// File: rtl/alu_result_tx_seq.sv
// Converts a captured ALU result to ASCII decimal and writes it, one character per
// accepted cycle, into the UART TX FIFO, optionally terminated by CR LF.
module alu_result_tx_seq
  import alu_uart_pkg::*;
#(
  parameter int unsigned NBIT   = 8,
  parameter bit          EOL_EN = 1'b1
) (
  input logic                CLK,
  input logic                RESET,
  alu_result_tx_seq_if.slave bus
);

  state_e     state_q;
  state_e     nxt_state;
  logic [7:0] data_q;
  logic       busy_q;
  logic       done_q;
  logic       conv_start;
  logic       conv_valid;
  logic       neg;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic       wr;

  assign conv_start = (state_q == StIdle) && bus.START;

  bin_to_dec_seq #(
    .NBIT (NBIT)
  ) u_b2d (
    .CLK   (CLK),
    .RESET (RESET),
    .start (conv_start),
    .value (bus.RESULT),
    .neg   (neg),
    .hund  (hund),
    .tens  (tens),
    .units (units),
    .valid (conv_valid)
  );

  always_comb begin
    wr        = is_emit(state_q) && !bus.FIFO_full;
    nxt_state = next_emit(state_q, neg, hund != 4'd0, tens != 4'd0, EOL_EN);
  end

  // StLatch covers the whole conversion; the sub-module walks its own sub-steps.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.START) begin
            state_q <= StLatch;
            busy_q  <= 1'b1;
          end
        end
        StLatch: begin
          if (conv_valid) begin
            state_q <= nxt_state;
            data_q  <= emit_char(nxt_state, hund, tens, units);
          end
        end
        StEmitSign, StEmitH, StEmitT, StEmitU, StEmitCr, StEmitLf: begin
          if (wr) begin
            state_q <= nxt_state;
            if (nxt_state == StFin) done_q <= 1'b1;
            else data_q <= emit_char(nxt_state, hund, tens, units);
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.WR_FIFO  = wr;
  assign bus.data_out = data_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_alu_result_tx_seq.sv
// Scoreboard bench for alu_result_tx_seq: expected characters are queued when a
// START is issued and popped as the DUT writes to the FIFO.
module tb_alu_result_tx_seq;

  logic clk;
  logic rst;

  alu_result_tx_seq_if #(.NBIT(8)) bus ();

  alu_result_tx_seq #(
    .NBIT   (8),
    .EOL_EN (1'b1)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int wr_count;
  int done_count;
  int first_wr_cyc;
  int last_wr_cyc;
  int start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    int n;
    if (!rst) begin
      if (bus.FIFO_full) check_eq("wr_while_full", {31'd0, bus.WR_FIFO}, 32'd0);
      if (bus.WR_FIFO) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
        n = exp_q.size();
        check_eq("wr_expected", {31'd0, n > 0}, 32'd1);
        if (n > 0) begin
          e = exp_q.pop_front();
          check_eq("char", {24'd0, bus.data_out}, {24'd0, e});
        end
      end
      if (bus.DONE) done_count++;
    end
  end

  task automatic push_expected(input logic [7:0] v);
    int s;
    int m;
    s = $signed(v);
    m = (s < 0) ? -s : s;
    if (s < 0) exp_q.push_back(8'h2D);
    if (m >= 100) exp_q.push_back(8'(8'h30 + m / 100));
    if (m >= 10) exp_q.push_back(8'(8'h30 + (m / 10) % 10));
    exp_q.push_back(8'(8'h30 + m % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic start_op(input logic [7:0] v);
    wr_count = 0;
    done_count = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    push_expected(v);
    @(posedge clk); #1;
    bus.START = 1'b1;
    bus.RESULT = v;
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.START = 1'b0;
    @(negedge clk);
    check_eq("busy_after_start", {31'd0, bus.BUSY}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.DONE) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
    check_eq({tag, "_latency"}, {31'd0, (first_wr_cyc >= 0) && (first_wr_cyc - start_cyc <= 13)},
             32'd1);
    @(negedge clk);
    check_eq({tag, "_busy_low"}, {31'd0, bus.BUSY}, 32'd0);
    check_eq({tag, "_done_pulse"}, {31'd0, bus.DONE}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic found;
    int wr_at_reset;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.RESULT = 8'h00;
    bus.FIFO_full = 1'b0;
    wr_count = 0;
    done_count = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    start_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr", {31'd0, bus.WR_FIFO}, 32'd0);
    check_eq("rst_data", {24'd0, bus.data_out}, 32'h00);
    check_eq("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check_eq("rst_done", {31'd0, bus.DONE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 123: five back-to-back characters then a single DONE.
    start_op(8'h7B);
    wait_done("p123");
    check_eq("p123_count", wr_count, 32'd5);
    check_eq("p123_back_to_back", last_wr_cyc - first_wr_cyc, 32'd4);
    check_eq("p123_done_count", done_count, 32'd1);

    start_op(8'h80);
    wait_done("m128");
    check_eq("m128_count", wr_count, 32'd6);

    start_op(8'h00);
    wait_done("zero");
    check_eq("zero_count", wr_count, 32'd3);

    start_op(8'h05);
    wait_done("five");
    check_eq("five_count", wr_count, 32'd3);

    // -10 with the FIFO full for four cycles while the tens digit is pending.
    start_op(8'hF6);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.WR_FIFO && bus.data_out == 8'h2D) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("m10_sign_seen", {31'd0, found}, 32'd1);
    @(posedge clk); #1;
    bus.FIFO_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("m10_hold_data", {24'd0, bus.data_out}, 32'h31);
      check_eq("m10_hold_wr", {31'd0, bus.WR_FIFO}, 32'd0);
    end
    @(posedge clk); #1;
    bus.FIFO_full = 1'b0;
    wait_done("m10");
    check_eq("m10_count", wr_count, 32'd5);

    // A second START while busy must not queue another result.
    start_op(8'h7B);
    repeat (2) @(posedge clk);
    #1;
    bus.START = 1'b1;
    bus.RESULT = 8'h05;
    @(posedge clk); #1;
    bus.START = 1'b0;
    wait_done("busy_ign");
    repeat (25) @(negedge clk);
    check_eq("busy_ign_count", wr_count, 32'd5);
    check_eq("busy_ign_done", done_count, 32'd1);

    // Reset during the tens digit of 99 drops the rest of the line.
    start_op(8'h63);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.WR_FIFO) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("r99_first_wr", {31'd0, found}, 32'd1);
    check_eq("r99_latency", {31'd0, (first_wr_cyc - start_cyc) <= 13}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("r99_rst_wr", {31'd0, bus.WR_FIFO}, 32'd0);
    check_eq("r99_rst_data", {24'd0, bus.data_out}, 32'h00);
    check_eq("r99_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check_eq("r99_rst_done", {31'd0, bus.DONE}, 32'd0);
    exp_q.delete();
    wr_at_reset = wr_count;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("r99_no_more_wr", wr_count, wr_at_reset);
    check_eq("r99_busy_idle", {31'd0, bus.BUSY}, 32'd0);

    start_op(8'h07);
    wait_done("seven");
    check_eq("seven_count", wr_count, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
